// File: rtl/md_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct3 operation codes, FSM state encoding and operand-signedness helpers.
package md_unit_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_WB   = 2'd3
    } md_state_e;

    // rs1 is interpreted as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic rs1_is_signed(input logic [2:0] f);
        return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) ||
               (f == MD_DIV) || (f == MD_REM);
    endfunction

    // rs2 is interpreted as signed for MUL, MULH, DIV and REM.
    function automatic logic rs2_is_signed(input logic [2:0] f);
        return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
// Multiply: {hi,lo} holds partial product and remaining multiplier bits;
//   add the multiplicand into hi when lo[0] is set, then shift right by one.
// Divide: hi holds the partial remainder, lo the dividend shifting out and the
//   quotient shifting in; trial-subtract the divisor and restore on borrow.
module md_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN:0]   hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] a,
    output logic [XLEN:0]   hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] r_sh;
    logic [XLEN:0] diff;

    // Single-step add-or-skip / trial-subtract, XLEN+1 bits wide.
    always_comb begin
        sum     = hi + {1'b0, a};
        r_sh    = {hi[XLEN-1:0], lo[XLEN-1]};
        diff    = r_sh - {1'b0, a};
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_next = diff;
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = r_sh;
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            if (!lo[0]) begin
                sum = hi;
            end
            hi_next = {1'b0, sum[XLEN:1]};
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit with a fixed-latency write-back strobe.
// Operands are made non-negative on accept, iterated XLEN times through md_step,
// then sign-corrected and muxed in FIX before a one-cycle RF write in WB.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            busy_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_wr_o,
    output logic [XLEN-1:0] wb_wd_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    md_state_e       state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      funct3_reg;
    logic [4:0]      rd_reg;
    logic            neg1_reg;
    logic            neg2_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN:0]   hi_reg;
    logic [XLEN-1:0] lo_reg;
    logic            busy_reg;
    logic            wb_we_reg;
    logic [4:0]      wb_wr_reg;
    logic [XLEN-1:0] wb_wd_reg;

    logic            neg1_in;
    logic            neg2_in;
    logic [XLEN-1:0] abs1_in;
    logic [XLEN-1:0] abs2_in;
    logic [XLEN:0]   hi_step;
    logic [XLEN-1:0] lo_step;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic            div_zero;
    logic [XLEN-1:0] fix_result;

    md_step #(.XLEN(XLEN)) u_step (
        .is_div  (funct3_reg[2]),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .a       (a_reg),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    // Operand sign capture and magnitude on the accept path.
    always_comb begin
        neg1_in = rs1_is_signed(funct3_i) && rs1_data_i[XLEN-1];
        neg2_in = rs2_is_signed(funct3_i) && rs2_data_i[XLEN-1];
        abs1_in = neg1_in ? -rs1_data_i : rs1_data_i;
        abs2_in = neg2_in ? -rs2_data_i : rs2_data_i;
    end

    // Sign correction and result selection; divide-by-zero keeps an all-ones
    // quotient, while the remainder naturally comes back as the original rs1.
    always_comb begin
        prod     = {hi_reg[XLEN-1:0], lo_reg};
        prod_fix = (neg1_reg ^ neg2_reg) ? -prod : prod;
        div_zero = (a_reg == '0);
        quo_fix  = ((neg1_reg ^ neg2_reg) && !div_zero) ? -lo_reg : lo_reg;
        if (div_zero) begin
            quo_fix = '1;
        end
        rem_fix  = neg1_reg ? -hi_reg[XLEN-1:0] : hi_reg[XLEN-1:0];
        case (funct3_reg)
            MD_MUL:                     fix_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU,
            MD_MULHU:                   fix_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:            fix_result = quo_fix;
            default:                    fix_result = rem_fix;
        endcase
    end

    // FSM with counter, datapath registers and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            funct3_reg <= '0;
            rd_reg     <= '0;
            neg1_reg   <= 1'b0;
            neg2_reg   <= 1'b0;
            a_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            wb_we_reg  <= 1'b0;
            wb_wr_reg  <= '0;
            wb_wd_reg  <= '0;
        end else begin
            wb_we_reg <= 1'b0;
            if (kill_i) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_i) begin
                            funct3_reg <= funct3_i;
                            rd_reg     <= rd_i;
                            neg1_reg   <= neg1_in;
                            neg2_reg   <= neg2_in;
                            a_reg      <= abs2_in;
                            hi_reg     <= '0;
                            lo_reg     <= abs1_in;
                            cnt_reg    <= '0;
                            busy_reg   <= 1'b1;
                            state_reg  <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        hi_reg  <= hi_step;
                        lo_reg  <= lo_step;
                        cnt_reg <= cnt_reg + CW'(1);
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        wb_wd_reg <= fix_result;
                        wb_wr_reg <= rd_reg;
                        wb_we_reg <= (rd_reg != 5'd0);
                        state_reg <= ST_WB;
                    end
                    default: begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o  = busy_reg;
    assign wb_we_o = wb_we_reg;
    assign wb_wr_o = wb_wr_reg;
    assign wb_wd_o = wb_wd_reg;

endmodule
